// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, rw/type encodings, arbiter state.
package sysbus_pkg;

    localparam int TAG_WIDTH = 13;
    localparam int BURST_BEATS = 8;

    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [3:0] MEMORY = 4'h1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WDATA,
        RESP
    } arb_state_t;

endpackage

// File: rtl/sysbus_arb_pick.sv
// Winner select for the two Sysbus requesters.
// SYSBUS_ARB_RR_EN: round-robin on last owner; otherwise port 1 always wins.
module sysbus_arb_pick (
    input  logic [1:0] reqcyc,
`ifdef SYSBUS_ARB_RR_EN
    input  logic       last,
`endif
    output logic       winner
);

`ifdef SYSBUS_ARB_RR_EN
    always_comb begin
        case (reqcyc)
            2'b11:   winner = ~last;
            2'b10:   winner = 1'b1;
            default: winner = 1'b0;
        endcase
    end
`else
    assign winner = reqcyc[1];
`endif

endmodule

// File: rtl/sysbus_arbiter.sv
// Fetch/LSU arbiter for the single Sysbus port, one transaction at a time.
// Arbitration policy selected by SYSBUS_ARB_RR_EN (see sysbus_arb_pick).
module sysbus_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = sysbus_pkg::TAG_WIDTH,
    parameter int BURST_BEATS = sysbus_pkg::BURST_BEATS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 m_reqcyc,
    input  logic [1:0][DATA_WIDTH-1:0] m_req,
    input  logic [1:0][TAG_WIDTH-1:0]  m_reqtag,
    output logic [1:0]                 m_reqack,
    output logic [1:0]                 m_respcyc,
    output logic [DATA_WIDTH-1:0]      m_resp,
    output logic                       bus_reqcyc,
    output logic [DATA_WIDTH-1:0]      bus_req,
    output logic [TAG_WIDTH-1:0]       bus_reqtag,
    input  logic                       bus_reqack,
    input  logic                       bus_respcyc,
    input  logic [DATA_WIDTH-1:0]      bus_resp,
    output logic                       bus_respack,
    output logic                       err
);
    import sysbus_pkg::*;

    localparam logic [2:0] LAST = 3'(BURST_BEATS - 1);

    arb_state_t state;
    logic       owner;
    logic       winner;
    logic       drain;
    logic [2:0] beat;
    logic       own_cyc;
    logic       own_rw;

    assign own_cyc = m_reqcyc[owner];
    assign own_rw  = m_reqtag[owner][TAG_WIDTH-1];

`ifdef SYSBUS_ARB_RR_EN
    logic last_owner;

    sysbus_arb_pick u_pick (
        .reqcyc (m_reqcyc),
        .last   (last_owner),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && |m_reqcyc) begin
            last_owner <= winner;
        end
    end
`else
    sysbus_arb_pick u_pick (
        .reqcyc (m_reqcyc),
        .winner (winner)
    );
`endif

    assign m_resp      = bus_resp;
    assign bus_respack = bus_respcyc;

    always_comb begin
        m_reqack   = '0;
        m_respcyc  = '0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        case (state)
            REQ: begin
                bus_reqcyc      = own_cyc;
                bus_req         = m_req[owner];
                bus_reqtag      = m_reqtag[owner];
                m_reqack[owner] = own_cyc & bus_reqack;
            end
            WDATA: begin
                bus_reqcyc = own_cyc;
                bus_req    = m_req[owner];
                bus_reqtag = m_reqtag[owner];
            end
            RESP: m_respcyc[owner] = bus_respcyc;
            default: ;
        endcase
    end

    // drain: a reset cut a transaction short, so its leftover beats
    // are swallowed silently until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            beat  <= '0;
            err   <= 1'b0;
            drain <= (state != IDLE);
        end else begin
            if (bus_respcyc && state != RESP && !drain) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|m_reqcyc) begin
                        owner <= winner;
                        drain <= 1'b0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                    end else if (bus_reqack) begin
                        beat  <= '0;
                        state <= (own_rw == WRITE) ? WDATA : RESP;
                    end
                end
                WDATA: begin
                    if (own_cyc) begin
                        beat <= beat + 3'd1;
                        if (beat == LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (bus_respcyc) begin
                        beat <= beat + 3'd1;
                        if (beat == LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: vector table plus corner sequences.
// Grant order expectation follows SYSBUS_ARB_RR_EN.
module tb_sysbus_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        m_reqcyc;
    logic [1:0][63:0]  m_req;
    logic [1:0][12:0]  m_reqtag;
    logic [1:0]        m_reqack;
    logic [1:0]        m_respcyc;
    logic [63:0]       m_resp;
    logic              bus_reqcyc;
    logic [63:0]       bus_req;
    logic [12:0]       bus_reqtag;
    logic              bus_reqack;
    logic              bus_respcyc;
    logic [63:0]       bus_resp;
    logic              bus_respack;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysbus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .m_reqcyc    (m_reqcyc),
        .m_req       (m_req),
        .m_reqtag    (m_reqtag),
        .m_reqack    (m_reqack),
        .m_respcyc   (m_respcyc),
        .m_resp      (m_resp),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_respack (bus_respack),
        .err         (err)
    );

    localparam logic [12:0] T_FETCH = 13'h1101;
    localparam logic [12:0] T_DRD   = 13'h1102;
    localparam logic [12:0] T_DWR   = 13'h0102;

    typedef struct {
        logic [1:0]  rc;
        logic [63:0] a0;
        logic [63:0] a1;
        logic        rack;
        logic        rcyc;
        logic [63:0] rdata;
        logic [1:0]  e_ack;
        logic [1:0]  e_rcyc;
        logic        e_bcyc;
        logic [63:0] e_breq;
        logic [12:0] e_btag;
        logic        e_rspack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic [1:0] rc, logic [63:0] a0, logic [63:0] a1,
        logic rack, logic rcyc, logic [63:0] rdata,
        logic [1:0] e_ack, logic [1:0] e_rcyc, logic e_bcyc,
        logic [63:0] e_breq, logic [12:0] e_btag, logic e_rspack
    );
        vec_t v;
        v.rc = rc; v.a0 = a0; v.a1 = a1;
        v.rack = rack; v.rcyc = rcyc; v.rdata = rdata;
        v.e_ack = e_ack; v.e_rcyc = e_rcyc; v.e_bcyc = e_bcyc;
        v.e_breq = e_breq; v.e_btag = e_btag;
        v.e_rspack = e_rspack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m_reqcyc    = '0;
        m_req       = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_in();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    bit   exp_g[3];
    bit   got;
    int   waitc;
    logic w;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SYSBUS_ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b1, 1'b1, 1'b1};
`endif
        m_reqtag[0] = T_FETCH;
        m_reqtag[1] = T_DRD;

        // fetch read at 0x1000, ack on third REQ cycle, 8 beats
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 64'h1000, 0, 0, 0, 0,
                         2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(2'b01, 64'h1000, 0, 0, 0, 0,
                             2'b00, 2'b00, 1, 64'h1000, T_FETCH, 0));
        tbl.push_back(mk(2'b01, 64'h1000, 0, 1, 0, 0,
                         2'b01, 2'b00, 1, 64'h1000, T_FETCH, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(2'b00, 0, 0, 0, 1, 64'(i),
                             2'b00, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        // port 1 granted, then withdraws before ack
        tbl.push_back(mk(2'b10, 0, 64'h2000, 0, 0, 0,
                         2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 64'h2000, 0, 0, 0,
                         2'b00, 2'b00, 1, 64'h2000, T_DRD, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0,
                         2'b00, 2'b00, 0, 0, T_DRD, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

        do_reset(2);
        foreach (tbl[i]) begin
            tick();
            m_reqcyc    = tbl[i].rc;
            m_req[0]    = tbl[i].a0;
            m_req[1]    = tbl[i].a1;
            bus_reqack  = tbl[i].rack;
            bus_respcyc = tbl[i].rcyc;
            bus_resp    = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_reqack", i), m_reqack, tbl[i].e_ack);
            chk($sformatf("v%0d_respcyc", i), m_respcyc, tbl[i].e_rcyc);
            chk($sformatf("v%0d_bcyc", i), bus_reqcyc, tbl[i].e_bcyc);
            chk($sformatf("v%0d_breq", i), bus_req, tbl[i].e_breq);
            chk($sformatf("v%0d_btag", i), bus_reqtag, tbl[i].e_btag);
            chk($sformatf("v%0d_rspack", i), bus_respack,
                tbl[i].e_rspack);
            chk($sformatf("v%0d_err", i), err, 1'b0);
            if (tbl[i].e_rcyc != 2'b00)
                chk($sformatf("v%0d_mresp", i), m_resp, tbl[i].rdata);
        end

        // contention: both ports hold read requests for 3 transactions
        do_reset(2);
        m_reqcyc = 2'b11;
        m_req[0] = 64'h3000;
        m_req[1] = 64'h4000;
        for (int t = 0; t < 3; t++) begin
            got   = 1'b0;
            waitc = 0;
            while (!got && waitc < 6) begin
                tick();
                bus_reqack  = 1'b0;
                bus_respcyc = 1'b0;
                #1;
                if (bus_reqcyc) got = 1'b1;
                else waitc++;
            end
            chk($sformatf("arb%0d_seen", t), got, 1'b1);
            if (got) begin
                w = exp_g[t];
                bus_reqack = 1'b1;
                #1;
                chk($sformatf("arb%0d_grant", t), m_reqack,
                    w ? 2'b10 : 2'b01);
                chk($sformatf("arb%0d_addr", t), bus_req,
                    w ? 64'h4000 : 64'h3000);
                for (int b = 0; b < 8; b++) begin
                    tick();
                    bus_reqack  = 1'b0;
                    bus_respcyc = 1'b1;
                    bus_resp    = 64'(t * 16 + b);
                    #1;
                    chk($sformatf("arb%0d_rcyc%0d", t, b), m_respcyc,
                        w ? 2'b10 : 2'b01);
                end
            end
        end

        // data write 0x2040, beats 0xA0..0xA7, then idle and withdraw
        do_reset(2);
        m_reqtag[1] = T_DWR;
        m_reqcyc    = 2'b10;
        m_req[1]    = 64'h2040;
        tick();
        chk("wr_bcyc", bus_reqcyc, 1'b1);
        chk("wr_addr", bus_req, 64'h2040);
        chk("wr_tag", bus_reqtag, T_DWR);
        bus_reqack = 1'b1;
        #1;
        chk("wr_ack", m_reqack, 2'b10);
        for (int b = 0; b < 8; b++) begin
            tick();
            bus_reqack = 1'b0;
            m_req[1]   = 64'hA0 + 64'(b);
            #1;
            chk($sformatf("wr_d%0d_cyc", b), bus_reqcyc, 1'b1);
            chk($sformatf("wr_d%0d", b), bus_req, 64'hA0 + 64'(b));
            chk($sformatf("wr_d%0d_rcyc", b), m_respcyc, 2'b00);
            chk($sformatf("wr_d%0d_ack", b), m_reqack, 2'b00);
        end
        tick();
        m_reqcyc    = 2'b01;
        m_req[0]    = 64'h5000;
        m_req[1]    = '0;
        m_reqtag[1] = T_DRD;
        #1;
        chk("wr_idle_bcyc", bus_reqcyc, 1'b0);
        tick();
        chk("wd_req0_bcyc", bus_reqcyc, 1'b1);
        chk("wd_req0_addr", bus_req, 64'h5000);
        tick();
        m_reqcyc = 2'b10;
        m_req[1] = 64'h6000;
        #1;
        chk("wd_drop_bcyc", bus_reqcyc, 1'b0);
        chk("wd_drop_ack", m_reqack, 2'b00);
        tick();
        chk("wd_idle_bcyc", bus_reqcyc, 1'b0);
        tick();
        bus_reqack = 1'b1;
        #1;
        chk("wd_p1_bcyc", bus_reqcyc, 1'b1);
        chk("wd_p1_addr", bus_req, 64'h6000);
        chk("wd_p1_ack", m_reqack, 2'b10);

        // stray response beat in IDLE
        do_reset(2);
        tick();
        bus_respcyc = 1'b1;
        #1;
        chk("stray_rspack", bus_respack, 1'b1);
        chk("stray_rcyc", m_respcyc, 2'b00);
        tick();
        bus_respcyc = 1'b0;
        #1;
        chk("stray_err", err, 1'b1);
        repeat (3) tick();
        chk("stray_err_hold", err, 1'b1);

        // reset during beat 4 of a fetch read
        do_reset(2);
        chk("rst_err_clr", err, 1'b0);
        m_reqcyc = 2'b01;
        m_req[0] = 64'h7000;
        tick();
        bus_reqack = 1'b1;
        #1;
        chk("mid_ack", m_reqack, 2'b01);
        for (int b = 0; b < 4; b++) begin
            tick();
            m_reqcyc    = 2'b00;
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b1;
            bus_resp    = 64'(b);
            if (b == 3) reset = 1'b1;
            #1;
            chk($sformatf("mid_b%0d_rcyc", b), m_respcyc, 2'b01);
        end
        for (int b = 4; b < 8; b++) begin
            tick();
            reset    = 1'b0;
            bus_resp = 64'(b);
            #1;
            chk($sformatf("mid_b%0d_rcyc", b), m_respcyc, 2'b00);
            chk($sformatf("mid_b%0d_rspack", b), bus_respack, 1'b1);
            chk($sformatf("mid_b%0d_bcyc", b), bus_reqcyc, 1'b0);
        end
        tick();
        bus_respcyc = 1'b0;
        #1;
        chk("mid_err", err, 1'b0);
        tick();
        chk("mid_err_hold", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Two-requester arbiter sharing the single Sysbus memory port between the core's instruction-fetch unit (port 0) and data-memory unit (port 1). It grants one whole transaction at a time and forwards the winner's request/address/tag and write-data beats to the bus. It routes the 8-beat read-response burst back to the owner and releases the bus when the transaction completes. It sits between the core's fetch/LSU logic and the `Sysbus` interface.

## Interface
- `DATA_WIDTH`, 64, request/response data width
- `TAG_WIDTH`, 13, `{rw[12], type[11:8], id[7:0]}`
- `BURST_BEATS`, 8, beats per 64-byte line
- `clk`  in  1  bus clock
- `reset`  in  1  reset; one clock, synchronous, active-high
- `m_reqcyc`  in  2  per-requester request valid
- `m_req`  in  2x`DATA_WIDTH`  address (REQ phase) / write data (WDATA phase)
- `m_reqtag`  in  2x`TAG_WIDTH`  request tag
- `m_reqack`  out  2  request accepted, one-hot to owner
- `m_respcyc`  out  2  response beat valid, one-hot to owner
- `m_resp`  out  `DATA_WIDTH`  response data, broadcast
- `bus_reqcyc`, `bus_req`, `bus_reqtag`  out  1/`DATA_WIDTH`/`TAG_WIDTH`  to Sysbus
- `bus_reqack`  in  1  from Sysbus
- `bus_respcyc`, `bus_resp`  in  1/`DATA_WIDTH`  from Sysbus
- `bus_respack`  out  1  to Sysbus
- `err`  out  1  sticky protocol error

## Operation
- States: IDLE, REQ, WDATA, RESP. `owner` (1 bit) and `beat` (3-bit counter) are registered.
- IDLE: if any `m_reqcyc`, select a winner, register `owner`, go to REQ.
- REQ:
  - Drive `bus_reqcyc = m_reqcyc[owner]`, `bus_req = m_req[owner]`, `bus_reqtag = m_reqtag[owner]`, combinationally.
  - On `bus_reqack`, pulse `m_reqack[owner]` in the same cycle and clear `beat`.
  - Next state is WDATA if `m_reqtag[owner][12]==WRITE`, else RESP.
- WDATA:
  - Pass through the owner's reqcyc/req as data beats; `beat` increments on each `bus_reqcyc`.
  - The owner must supply one beat per cycle with no gaps.
  - After beat 7 (`beat==7` and `bus_reqcyc`), go to IDLE.
- RESP:
  - `m_respcyc[owner] = bus_respcyc`, `m_resp = bus_resp`; `beat` increments per beat.
  - After beat 7, go to IDLE.
- `bus_respack = bus_respcyc` in every state. Requesters must accept every forwarded beat.
- Outside REQ/WDATA, all bus request outputs are 0.
- Stray `bus_respcyc` in IDLE/REQ/WDATA: acked, not forwarded, sets `err`.
- Non-owner `m_reqack`/`m_respcyc` are always 0. A losing requester holds its request until granted.
- Owner dropping `m_reqcyc` in REQ before ack: the request is withdrawn and the arbiter returns to IDLE next cycle.

## Timing
- Reset values: state IDLE, `owner` 0, `beat` 0, `err` 0, RR pointer favours port 1. All outputs are 0 except `m_resp` (don't-care) and `bus_respack` (follows `bus_respcyc`).
- Reset mid-transaction abandons the transaction: outputs return to reset values on the next edge. Bursts still in flight are acked and dropped without setting `err`, until the next grant.
- Arbitration latency: `m_reqcyc` rises in cycle N (IDLE), `bus_reqcyc` rises in N+1.
- Ack and response paths are zero-latency (combinational).
- After the last beat in cycle M, IDLE in M+1; the next grant's `bus_reqcyc` is in M+2 at the earliest.
- `beat` wraps 7→0; there is no other wrap.

## Configuration
- `SYSBUS_ARB_RR_EN` defined: round-robin. The pointer records the last owner; on contention, the other port wins.
- Undefined: fixed priority, port 1 (data) always beats port 0 (fetch). The pointer logic is removed.

## Structure
- Package `sysbus_pkg`: `TAG_WIDTH`, `BURST_BEATS`, rw encoding (`READ=1'b1`, `WRITE=1'b0`), type codes (`MEMORY`), `arb_state_t` enum.
- One sub-module, `sysbus_arb_pick`: winner select from `m_reqcyc` and pointer, compiled per `SYSBUS_ARB_RR_EN`.

## Test plan
- Single fetch read at `0x1000`, ack after 3 cycles:
  - `bus_reqcyc` one cycle after `m_reqcyc[0]`, with `bus_req=0x1000`.
  - `m_reqack[0]` coincides with `bus_reqack`.
  - 8 beats `0x0..0x7` appear only on `m_respcyc[0]`/`m_resp`.
  - IDLE after the 8th beat.
- Simultaneous requests, both held for 3 transactions:
  - RR: grants alternate 1,0,1.
  - Fixed priority: port 1 is granted repeatedly and port 0 waits.
- Data write to `0x2040` with data beats `0xA0..0xA7`:
  - Bus sees address, then 8 data beats in consecutive cycles.
  - No response is forwarded; IDLE after beat 8.
- Stray `bus_respcyc` in IDLE: `bus_respack=1`, no `m_respcyc`, `err=1` and stays set.
- Reset asserted during beat 4 of a read:
  - Next cycle: IDLE, outputs 0.
  - Remaining 4 beats acked and not forwarded; `err` stays 0.
- Port 0 drops `m_reqcyc` in REQ before ack: arbiter in IDLE next cycle; a pending port 1 request is granted the following cycle.
